midi_voice_allocator: RTL and testbench
=======================================

Name: midi_voice_allocator

Overview:
Polyphonic voice scheduler between the MIDI byte/message parser and the N oscillator/envelope voices. It accepts decoded note events over a valid/ready handshake. It assigns each note-on to a voice: same-note retrigger first, then the lowest free voice, then the oldest voice is stolen. It releases voices on note-off and all-notes-off and drives per-voice gate, note, velocity and trigger outputs.

Parameters:
NUM_VOICES, 4, number of voices managed (2..16)
AGE_W, 8, width of per-voice age counter (saturating)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
ev_valid  input  1  event present
ev_ready  output  1  allocator can accept an event (high only in IDLE)
ev_type  input  2  0=note off, 1=note on, 2=all notes off, 3=ignored
ev_note  input  7  MIDI note number
ev_velocity  input  7  MIDI velocity
voice_gate  output  NUM_VOICES  per-voice key-down
voice_note  output  7*NUM_VOICES  note per voice; voice i at [7i+6:7i]
voice_velocity  output  7*NUM_VOICES  velocity per voice, same packing
voice_trigger  output  NUM_VOICES  one-cycle pulse: voice (re)started
steal_pulse  output  1  one-cycle pulse: an active voice was stolen

Behaviour:
- Single clock domain. Reset is synchronous and active-high. On reset, voice_gate, voice_note, voice_velocity, voice_trigger, steal_pulse and all ages are 0, and the FSM goes to IDLE.
- ev_ready = (state==IDLE) && !reset. An event is accepted when ev_valid && ev_ready; ev_type, ev_note and ev_velocity are latched then. Inputs are ignored otherwise.
- Note on with velocity 0 is treated as note off. Type 3 is accepted and discarded, returning to IDLE the next cycle with no output change.
- FSM states:
  - IDLE: on accept, go to SCAN with idx=0.
  - SCAN: examines voice idx in one cycle per voice, idx 0..NUM_VOICES-1. It records:
    - match: lowest gated voice with voice_note == latched note;
    - free: lowest voice with gate=0;
    - oldest: gated voice with maximum age, ties to the lowest index.
    After idx=NUM_VOICES-1, go to COMMIT.
  - COMMIT: applies the update in one cycle, then returns to IDLE.
- Latency: accept at cycle T gives outputs updated and pulses high at T+NUM_VOICES+1; ev_ready is high again at T+NUM_VOICES+2. Back-to-back throughput is one event per NUM_VOICES+2 cycles.
- Note-on commit picks the target voice in this order: match if found, else free, else oldest (steal).
  - Target: gate=1, note and velocity written, age=0, voice_trigger[target]=1 for one cycle.
  - All other gated voices: age += 1, saturating at 2^AGE_W-1.
  - steal_pulse=1 for one cycle only in the steal case.
  - Retrigger (match) is not a steal.
- Note-off commit: if a match exists, clear its gate. Note, velocity and age are kept so the envelope release continues. If there is no match, nothing changes and no pulses are generated.
- All-notes-off commit: clear every gate. Notes, velocities and ages are kept. No pulses.
- Gated voices never hold duplicate notes, because retrigger reuses the existing voice.
- Ages of ungated voices are don't-care for selection, since free voices are always preferred.
- voice_trigger and steal_pulse are registered and otherwise 0.
- Reset asserted in SCAN or COMMIT aborts the event; no partial update becomes visible.
- ev_valid may drop while ev_ready is low without effect; the already-latched event completes.

Test Plan:
- Reset, then note on 60 vel 100: voice_gate=0001, voice_note[0]=60, voice_trigger=0001 pulse at accept+5 cycles (NUM_VOICES=4), ev_ready high at accept+6.
- Note on 60, 64, 67, 71, then note off 64: gates go 1111 then 1101; voice 1 note stays 64; a following note on 72 lands on voice 1 with trigger=0010 and no steal_pulse.
- Four voices held (60, 62, 64, 65 in order), then note on 67: voice 0 (oldest, age 3) gets note 67, steal_pulse=1, trigger=0001; the next note on 69 steals voice 1.
- Note on 60 vel 100, then note on 60 vel 20: still only voice 0 gated, velocity 20, trigger=0001 again, ages of other voices unchanged.
- Note on 62 vel 0 with 62 held on voice 2 releases voice 2. Note off 50 with 50 not held causes no change and no pulses. Type 2 with three voices held gives voice_gate=0000.
- Reset asserted during SCAN after a note on: outputs all zero, ev_ready high the cycle after reset drops, no trigger pulse ever appears.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: takes decoded note events and assigns them to
// NUM_VOICES voices (retrigger, then lowest free voice, then steal the oldest).
module midi_voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic [1:0]              ev_type,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_velocity,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_trigger,
  output logic                    steal_pulse
);

  localparam int unsigned IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned NOTE_W = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_OFF     = 2'd0,
    K_ON      = 2'd1,
    K_ALL_OFF = 2'd2,
    K_NONE    = 2'd3
  } kind_e;

  state_e                                state_q, state_d;
  kind_e                                 kind_q, kind_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [NOTE_W-1:0]                     ev_note_q, ev_note_d;
  logic [NOTE_W-1:0]                     ev_vel_q, ev_vel_d;

  logic                                  match_found_q, match_found_d;
  logic [IDX_W-1:0]                      match_idx_q, match_idx_d;
  logic                                  free_found_q, free_found_d;
  logic [IDX_W-1:0]                      free_idx_q, free_idx_d;
  logic                                  old_found_q, old_found_d;
  logic [IDX_W-1:0]                      old_idx_q, old_idx_d;
  logic [AGE_W-1:0]                      old_age_q, old_age_d;

  logic [NUM_VOICES-1:0]                 gate_q, gate_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]     note_q, note_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]     vel_q, vel_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]      age_q, age_d;
  logic [NUM_VOICES-1:0]                 trig_q, trig_d;
  logic                                  steal_q, steal_d;

  logic                                  accept;
  logic [IDX_W-1:0]                      target;
  logic                                  is_last;

  assign ev_ready = (state_q == S_IDLE) && !reset;
  assign accept   = ev_valid && ev_ready;
  assign is_last  = (idx_q == IDX_W'(NUM_VOICES - 1));

  assign voice_gate     = gate_q;
  assign voice_note     = note_q;
  assign voice_velocity = vel_q;
  assign voice_trigger  = trig_q;
  assign steal_pulse    = steal_q;

  // Next-state: event latch, per-voice scan, and the single-cycle commit.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    idx_d         = idx_q;
    ev_note_d     = ev_note_q;
    ev_vel_d      = ev_vel_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    gate_d        = gate_q;
    note_d        = note_q;
    vel_d         = vel_q;
    age_d         = age_q;
    trig_d        = '0;
    steal_d       = 1'b0;
    target        = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ev_note_d = ev_note;
          ev_vel_d  = ev_velocity;
          if ((kind_e'(ev_type) == K_ON) && (ev_velocity == 7'd0)) begin
            kind_d = K_OFF;
          end else begin
            kind_d = kind_e'(ev_type);
          end
          // Ignored events are consumed without leaving IDLE.
          if (kind_e'(ev_type) != K_NONE) begin
            state_d       = S_SCAN;
            idx_d         = '0;
            match_found_d = 1'b0;
            match_idx_d   = '0;
            free_found_d  = 1'b0;
            free_idx_d    = '0;
            old_found_d   = 1'b0;
            old_idx_d     = '0;
            old_age_d     = '0;
          end
        end
      end

      S_SCAN: begin
        if (!match_found_q && gate_q[idx_q] && (note_q[idx_q] == ev_note_q)) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!free_found_q && !gate_q[idx_q]) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict compare keeps ties on the lower index.
        if (gate_q[idx_q] && (!old_found_q || (age_q[idx_q] > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = age_q[idx_q];
        end
        if (is_last) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        case (kind_q)
          K_ON: begin
            if (match_found_q) begin
              target = match_idx_q;
            end else if (free_found_q) begin
              target = free_idx_q;
            end else begin
              target = old_idx_q;
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == target) begin
                gate_d[i] = 1'b1;
                note_d[i] = ev_note_q;
                vel_d[i]  = ev_vel_q;
                age_d[i]  = '0;
                trig_d[i] = 1'b1;
              end else if (gate_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
                age_d[i] = age_q[i] + AGE_W'(1);
              end
            end
            steal_d = !match_found_q && !free_found_q;
          end
          K_OFF: begin
            if (match_found_q) begin
              gate_d[match_idx_q] = 1'b0;
            end
          end
          K_ALL_OFF: begin
            gate_d = '0;
          end
          default: begin
          end
        endcase
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset also aborts any in-flight event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kind_q        <= K_NONE;
      idx_q         <= '0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      gate_q        <= '0;
      note_q        <= '0;
      vel_q         <= '0;
      age_q         <= '0;
      trig_q        <= '0;
      steal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      idx_q         <= idx_d;
      ev_note_q     <= ev_note_d;
      ev_vel_q      <= ev_vel_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      gate_q        <= gate_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
      trig_q        <= trig_d;
      steal_q       <= steal_d;
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios plus random events
// compared against a list-style voice model.
module tb_midi_voice_allocator;

  localparam int NV      = 4;
  localparam int AW      = 2;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic [1:0]      ev_type = 2'd0;
  logic [6:0]      ev_note = 7'd0;
  logic [6:0]      ev_velocity = 7'd0;
  logic [NV-1:0]   voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_velocity;
  logic [NV-1:0]   voice_trigger;
  logic            steal_pulse;

  midi_voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk(clk), .reset(reset),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_note(ev_note), .ev_velocity(ev_velocity),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_velocity(voice_velocity),
    .voice_trigger(voice_trigger), .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int passes = 0;

  // Reference voice table
  int m_gate[NV];
  int m_note[NV];
  int m_vel[NV];
  int m_age[NV];
  logic [NV-1:0] exp_trig;
  logic          exp_steal;

  logic [NV-1:0] pre_trig;
  logic          pre_steal;
  logic          pre_ready;
  int            acc_cycle;

  function automatic void model_clear();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
    exp_trig = '0;
    exp_steal = 1'b0;
  endfunction

  function automatic void model_apply(input int t, input int n, input int v);
    int match, tgt, best;
    exp_trig = '0;
    exp_steal = 1'b0;
    if (t == 3) return;
    if (t == 1 && v == 0) t = 0;
    if (t == 2) begin
      for (int i = 0; i < NV; i++) m_gate[i] = 0;
      return;
    end
    match = -1;
    for (int i = NV - 1; i >= 0; i--) if (m_gate[i] != 0 && m_note[i] == n) match = i;
    if (t == 0) begin
      if (match >= 0) m_gate[match] = 0;
      return;
    end
    tgt = match;
    if (tgt < 0) for (int i = NV - 1; i >= 0; i--) if (m_gate[i] == 0) tgt = i;
    if (tgt < 0) begin
      best = -1;
      for (int i = 0; i < NV; i++) if (best < 0 || m_age[i] > m_age[best]) best = i;
      tgt = best;
      exp_steal = 1'b1;
    end
    for (int i = 0; i < NV; i++)
      if (i != tgt && m_gate[i] != 0 && m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
    m_gate[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v; m_age[tgt] = 0;
    exp_trig[tgt] = 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Drives one event and returns #1 after the commit edge (accept edge for type 3).
  task automatic send_event(input logic [1:0] t, input logic [6:0] n, input logic [6:0] v);
    int waited = 0;
    @(negedge clk);
    while (!ev_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ev_ready) begin
      checks++;
      $display("FAIL ready_timeout: ev_ready=%0b want 1 after %0d cycles", ev_ready, waited);
    end
    ev_valid = 1'b1; ev_type = t; ev_note = n; ev_velocity = v;
    @(posedge clk);
    #1;
    acc_cycle = cycle;
    ev_valid = 1'b0;
    ev_type = 2'($urandom); ev_note = 7'($urandom); ev_velocity = 7'($urandom);
    model_apply(int'(t), int'(n), int'(v));
    if (t == 2'd3) begin
      pre_trig = voice_trigger; pre_steal = steal_pulse; pre_ready = ev_ready;
      return;
    end
    repeat (4) @(posedge clk);
    #1;
    pre_trig = voice_trigger; pre_steal = steal_pulse; pre_ready = ev_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ev_ready !== 1'b0) $display("FAIL reset_ready_low: got %0b want 0", ev_ready);
    else passes++;
    checks++;
    if ({voice_gate, voice_note, voice_velocity, voice_trigger, steal_pulse} !== '0)
      $display("FAIL reset_outputs: gate=%0h note=%0h vel=%0h trig=%0h steal=%0b want all 0",
               voice_gate, voice_note, voice_velocity, voice_trigger, steal_pulse);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (ev_ready !== 1'b1) $display("FAIL reset_ready_high: got %0b want 1", ev_ready);
    else passes++;
  endtask

  task automatic test_first_note();
    do_reset();
    send_event(2'd1, 7'd60, 7'd100);
    checks++;
    if (pre_trig !== 4'b0000 || pre_ready !== 1'b0)
      $display("FAIL first_early: trig=%0b ready=%0b one cycle early want 0000/0", pre_trig, pre_ready);
    else passes++;
    checks++;
    if (voice_trigger !== 4'b0001 || voice_gate !== 4'b0001)
      $display("FAIL first_commit: trig=%0b gate=%0b want 0001/0001", voice_trigger, voice_gate);
    else passes++;
    checks++;
    if (voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100)
      $display("FAIL first_data: note=%0d vel=%0d want 60/100", voice_note[6:0], voice_velocity[6:0]);
    else passes++;
    checks++;
    if (ev_ready !== 1'b1) $display("FAIL first_ready: got %0b want 1", ev_ready);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (voice_trigger !== 4'b0000) $display("FAIL first_pulse_width: trig=%0b want 0000", voice_trigger);
    else passes++;
  endtask

  task automatic test_note_off();
    do_reset();
    send_event(2'd1, 7'd60, 7'd90);
    send_event(2'd1, 7'd64, 7'd90);
    send_event(2'd1, 7'd67, 7'd90);
    send_event(2'd1, 7'd71, 7'd90);
    checks++;
    if (voice_gate !== 4'b1111) $display("FAIL off_fill: gate=%0b want 1111", voice_gate);
    else passes++;
    send_event(2'd0, 7'd64, 7'd0);
    checks++;
    if (voice_gate !== 4'b1101 || voice_note[13:7] !== 7'd64)
      $display("FAIL off_release: gate=%0b note1=%0d want 1101/64", voice_gate, voice_note[13:7]);
    else passes++;
    send_event(2'd1, 7'd72, 7'd50);
    checks++;
    if (voice_trigger !== 4'b0010 || steal_pulse !== 1'b0 || voice_note[13:7] !== 7'd72)
      $display("FAIL off_reuse: trig=%0b steal=%0b note1=%0d want 0010/0/72",
               voice_trigger, steal_pulse, voice_note[13:7]);
    else passes++;
  endtask

  task automatic test_steal();
    do_reset();
    send_event(2'd1, 7'd60, 7'd80);
    send_event(2'd1, 7'd62, 7'd80);
    send_event(2'd1, 7'd64, 7'd80);
    send_event(2'd1, 7'd65, 7'd80);
    send_event(2'd1, 7'd67, 7'd81);
    checks++;
    if (voice_trigger !== 4'b0001 || steal_pulse !== 1'b1 || voice_note[6:0] !== 7'd67)
      $display("FAIL steal_first: trig=%0b steal=%0b note0=%0d want 0001/1/67",
               voice_trigger, steal_pulse, voice_note[6:0]);
    else passes++;
    send_event(2'd1, 7'd69, 7'd82);
    checks++;
    if (voice_trigger !== 4'b0010 || steal_pulse !== 1'b1 || voice_note[13:7] !== 7'd69)
      $display("FAIL steal_second: trig=%0b steal=%0b note1=%0d want 0010/1/69",
               voice_trigger, steal_pulse, voice_note[13:7]);
    else passes++;
  endtask

  task automatic test_retrigger();
    do_reset();
    send_event(2'd1, 7'd60, 7'd100);
    send_event(2'd1, 7'd60, 7'd20);
    checks++;
    if (voice_gate !== 4'b0001 || voice_trigger !== 4'b0001 || steal_pulse !== 1'b0 ||
        voice_velocity[6:0] !== 7'd20)
      $display("FAIL retrigger: gate=%0b trig=%0b steal=%0b vel0=%0d want 0001/0001/0/20",
               voice_gate, voice_trigger, steal_pulse, voice_velocity[6:0]);
    else passes++;
  endtask

  task automatic test_release_cases();
    do_reset();
    send_event(2'd1, 7'd58, 7'd70);
    send_event(2'd1, 7'd59, 7'd70);
    send_event(2'd1, 7'd62, 7'd70);
    send_event(2'd1, 7'd62, 7'd0);
    checks++;
    if (voice_gate !== 4'b0011 || voice_trigger !== 4'b0000 || voice_note[20:14] !== 7'd62)
      $display("FAIL vel0_off: gate=%0b trig=%0b note2=%0d want 0011/0000/62",
               voice_gate, voice_trigger, voice_note[20:14]);
    else passes++;
    send_event(2'd1, 7'd62, 7'd40);
    send_event(2'd0, 7'd50, 7'd0);
    checks++;
    if (voice_gate !== 4'b0111 || voice_trigger !== 4'b0000 || steal_pulse !== 1'b0)
      $display("FAIL off_unheld: gate=%0b trig=%0b steal=%0b want 0111/0000/0",
               voice_gate, voice_trigger, steal_pulse);
    else passes++;
    send_event(2'd2, 7'd0, 7'd0);
    checks++;
    if (voice_gate !== 4'b0000 || voice_trigger !== 4'b0000 || voice_note[20:14] !== 7'd62)
      $display("FAIL all_off: gate=%0b trig=%0b note2=%0d want 0000/0000/62",
               voice_gate, voice_trigger, voice_note[20:14]);
    else passes++;
  endtask

  task automatic test_ignored();
    do_reset();
    send_event(2'd1, 7'd61, 7'd33);
    send_event(2'd3, 7'd61, 7'd99);
    checks++;
    if (voice_gate !== 4'b0001 || pre_trig !== 4'b0000 || voice_velocity[6:0] !== 7'd33)
      $display("FAIL type3: gate=%0b trig=%0b vel0=%0d want 0001/0000/33",
               voice_gate, pre_trig, voice_velocity[6:0]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int first;
    do_reset();
    send_event(2'd1, 7'd40, 7'd10);
    first = acc_cycle;
    send_event(2'd1, 7'd41, 7'd11);
    checks++;
    if (acc_cycle - first !== NV + 2)
      $display("FAIL back_to_back: spacing=%0d want %0d", acc_cycle - first, NV + 2);
    else passes++;
  endtask

  task automatic test_reset_abort();
    logic [NV-1:0] seen;
    do_reset();
    @(negedge clk);
    ev_valid = 1'b1; ev_type = 2'd1; ev_note = 7'd60; ev_velocity = 7'd100;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (ev_ready !== 1'b1 || {voice_gate, voice_note, voice_velocity, voice_trigger, steal_pulse} !== '0)
      $display("FAIL abort_state: ready=%0b gate=%0b note=%0h want 1/0/0", ev_ready, voice_gate, voice_note);
    else passes++;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      seen = seen | voice_trigger;
    end
    checks++;
    if (seen !== 4'b0000) $display("FAIL abort_no_trigger: seen=%0b want 0000", seen);
    else passes++;
  endtask

  task automatic test_random();
    logic [NV-1:0]   eg;
    logic [7*NV-1:0] en, evl;
    logic [1:0]      t;
    logic [6:0]      n, v;
    int              r;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12) t = 2'd1;
      else if (r < 17) t = 2'd0;
      else if (r < 18) t = 2'd2;
      else t = 2'd3;
      n = 7'(60 + $urandom_range(0, 5));
      v = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      send_event(t, n, v);
      for (int i = 0; i < NV; i++) begin
        eg[i] = (m_gate[i] != 0);
        en[7*i +: 7] = 7'(m_note[i]);
        evl[7*i +: 7] = 7'(m_vel[i]);
      end
      checks++;
      if (voice_gate !== eg || voice_note !== en || voice_velocity !== evl)
        $display("FAIL rand_state[%0d]: gate=%0b note=%0h vel=%0h want %0b/%0h/%0h",
                 k, voice_gate, voice_note, voice_velocity, eg, en, evl);
      else passes++;
      checks++;
      if ((t == 2'd3 ? pre_trig : voice_trigger) !== exp_trig ||
          (t == 2'd3 ? pre_steal : steal_pulse) !== exp_steal)
        $display("FAIL rand_pulse[%0d]: trig=%0b steal=%0b want %0b/%0b",
                 k, voice_trigger, steal_pulse, exp_trig, exp_steal);
      else passes++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_note();
    test_note_off();
    test_steal();
    test_retrigger();
    test_release_cases();
    test_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
